m68k_bus_master: RTL

Synthesizable 68000-style bus-cycle initiator that drives the CPU side of the gstmcu/gstshifter bus (AS_N, UDS_N, LDS_N, RW, FC, A, DIN) and terminates cycles on DTACK_N, BERR_N or VPA_N. It stands in for the CPU in simulation and FPGA bring-up, and is paced by the MCU's MHZ8_EN1/MHZ8_EN2 phase strobes. A simple request/acknowledge port on the user side lets a sequencer issue word and byte reads and writes. It also grants the bus on BR_N and generates the 6800 E clock and VMA_N.

---
 rtl/m68k_bus_master.sv | 262 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/m68k_bus_master.sv
// 68000-style bus-cycle initiator for the MCU/shifter bus.
//
// Stands in for the CPU: runs word/byte read and write cycles (half-states S0..S7 with
// wait states), terminates them on DTACK_N, BERR_N or VPA_N, grants the bus on BR_N, and
// generates the 6800 E clock together with VMA_N. It is paced by the MCU phase strobes:
// S0/S2/S4/S6 begin on mhz8_en1_i (ph_rise) and S1/S3/S5/S7 begin on mhz8_en2_i (ph_fall).
//
// Ports
//   clk32_i, reset_i          32 MHz clock, asynchronous active-high reset
//   mhz8_en1_i, mhz8_en2_i    one-clk32 CPU-clock rise/fall strobes
//   req_*_i                   user request (sampled only when idle at ph_rise)
//   ack_o, berr_o, rdata_o    completion pulse, bus-error flag, read data
//   busy_o                    bus cycle or bus grant in progress
//   as_n_o .. vma_n_o         68000 bus strobes
//   fc_o, a_o, dout_o         function code, word address, write data
//   din_i                     read data from the bus
//   dtack_n_i, berr_n_i,
//   vpa_n_i, br_n_i           termination and bus-request inputs
//   bg_n_o                    bus grant
//   e_o                       6800 enable clock (6 low, 4 high CPU clocks)
module m68k_bus_master (
    input  logic        clk32_i,
    input  logic        reset_i,
    input  logic        mhz8_en1_i,
    input  logic        mhz8_en2_i,
    input  logic        req_i,
    input  logic        req_we_i,
    input  logic [22:0] req_addr_i,
    input  logic        req_uds_i,
    input  logic        req_lds_i,
    input  logic [2:0]  req_fc_i,
    input  logic [15:0] req_wdata_i,
    output logic        ack_o,
    output logic        berr_o,
    output logic [15:0] rdata_o,
    output logic        busy_o,
    output logic        as_n_o,
    output logic        uds_n_o,
    output logic        lds_n_o,
    output logic        rw_o,
    output logic        vma_n_o,
    output logic [2:0]  fc_o,
    output logic [22:0] a_o,
    output logic [15:0] dout_o,
    input  logic [15:0] din_i,
    input  logic        dtack_n_i,
    input  logic        berr_n_i,
    input  logic        vpa_n_i,
    input  logic        br_n_i,
    output logic        bg_n_o,
    output logic        e_o
);

    typedef enum logic [3:0] {
        StIdle,
        StS0,
        StS1,
        StS2,
        StS3,
        StS4,
        StWait,
        StS5,
        StS6,
        StS7,
        StEWait,
        StGrant
    } state_e;

    state_e      state_q;

    // Latched request fields
    logic        we_q;
    logic        uds_q;
    logic        lds_q;
    logic [15:0] wdata_q;

    // Registered outputs
    logic        ack_q;
    logic        berr_q;
    logic [15:0] rdata_q;
    logic        busy_q;
    logic        as_n_q;
    logic        uds_n_q;
    logic        lds_n_q;
    logic        rw_q;
    logic        vma_n_q;
    logic [2:0]  fc_q;
    logic [22:0] a_q;
    logic [15:0] dout_q;
    logic        bg_n_q;

    // E clock: free-running 0..9 count of ph_fall strobes
    logic [3:0]  ecnt_q;
    logic [3:0]  ecnt_nxt;
    logic        e_q;

    always_comb begin
        ecnt_nxt = (ecnt_q == 4'd9) ? 4'd0 : ecnt_q + 4'd1;
    end

    always_ff @(posedge clk32_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            we_q    <= 1'b0;
            uds_q   <= 1'b0;
            lds_q   <= 1'b0;
            wdata_q <= 16'h0000;
            ack_q   <= 1'b0;
            berr_q  <= 1'b0;
            rdata_q <= 16'h0000;
            busy_q  <= 1'b0;
            as_n_q  <= 1'b1;
            uds_n_q <= 1'b1;
            lds_n_q <= 1'b1;
            rw_q    <= 1'b1;
            vma_n_q <= 1'b1;
            fc_q    <= 3'd0;
            a_q     <= 23'd0;
            dout_q  <= 16'h0000;
            bg_n_q  <= 1'b1;
            ecnt_q  <= 4'd0;
            e_q     <= 1'b0;
        end else begin
            ack_q <= 1'b0;

            if (mhz8_en2_i) begin
                ecnt_q <= ecnt_nxt;
                e_q    <= (ecnt_nxt >= 4'd6);
            end

            unique case (state_q)
                StIdle: begin
                    if (mhz8_en1_i) begin
                        // Bus request wins over a pending user request
                        if (!br_n_i) begin
                            bg_n_q  <= 1'b0;
                            busy_q  <= 1'b1;
                            state_q <= StGrant;
                        end else if (req_i) begin
                            we_q    <= req_we_i;
                            uds_q   <= req_uds_i;
                            lds_q   <= req_lds_i;
                            wdata_q <= req_wdata_i;
                            a_q     <= req_addr_i;
                            fc_q    <= req_fc_i;
                            rw_q    <= ~req_we_i;
                            busy_q  <= 1'b1;
                            state_q <= StS0;
                        end
                    end
                end
                StS0: begin
                    if (mhz8_en2_i) state_q <= StS1;
                end
                StS1: begin
                    if (mhz8_en1_i) begin
                        as_n_q <= 1'b0;
                        // Reads assert the data strobes together with AS_N
                        if (!we_q) begin
                            uds_n_q <= ~uds_q;
                            lds_n_q <= ~lds_q;
                        end
                        state_q <= StS2;
                    end
                end
                StS2: begin
                    if (mhz8_en2_i) begin
                        if (we_q) dout_q <= wdata_q;
                        state_q <= StS3;
                    end
                end
                StS3: begin
                    if (mhz8_en1_i) begin
                        if (we_q) begin
                            uds_n_q <= ~uds_q;
                            lds_n_q <= ~lds_q;
                        end
                        state_q <= StS4;
                    end
                end
                StS4, StWait: begin
                    // Termination sampled at each ph_fall; none low means one more wait state
                    if (mhz8_en2_i) begin
                        if (!berr_n_i) begin
                            berr_q  <= 1'b1;
                            state_q <= StS5;
                        end else if (!dtack_n_i) begin
                            berr_q  <= 1'b0;
                            state_q <= StS5;
                        end else if (!vpa_n_i) begin
                            berr_q  <= 1'b0;
                            state_q <= StEWait;
                        end else begin
                            state_q <= StWait;
                        end
                    end
                end
                StS5: begin
                    if (mhz8_en1_i) state_q <= StS6;
                end
                StS6: begin
                    if (mhz8_en2_i) begin
                        if (!we_q && !berr_q) rdata_q <= din_i;
                        as_n_q  <= 1'b1;
                        uds_n_q <= 1'b1;
                        lds_n_q <= 1'b1;
                        state_q <= StS7;
                    end
                end
                StS7: begin
                    if (mhz8_en1_i) begin
                        ack_q   <= 1'b1;
                        rw_q    <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                StEWait: begin
                    // VMA_N goes low at the first ph_rise with count 2; the cycle then
                    // ends on the ph_fall where E falls (count wraps 9 -> 0).
                    if (mhz8_en1_i && vma_n_q && (ecnt_q == 4'd2)) begin
                        vma_n_q <= 1'b0;
                    end
                    if (mhz8_en2_i && !vma_n_q && (ecnt_q == 4'd9)) begin
                        if (!we_q) rdata_q <= din_i;
                        as_n_q  <= 1'b1;
                        uds_n_q <= 1'b1;
                        lds_n_q <= 1'b1;
                        vma_n_q <= 1'b1;
                        state_q <= StS7;
                    end
                end
                StGrant: begin
                    if (mhz8_en1_i && br_n_i) begin
                        bg_n_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign ack_o   = ack_q;
    assign berr_o  = berr_q;
    assign rdata_o = rdata_q;
    assign busy_o  = busy_q;
    assign as_n_o  = as_n_q;
    assign uds_n_o = uds_n_q;
    assign lds_n_o = lds_n_q;
    assign rw_o    = rw_q;
    assign vma_n_o = vma_n_q;
    assign fc_o    = fc_q;
    assign a_o     = a_q;
    assign dout_o  = dout_q;
    assign bg_n_o  = bg_n_q;
    assign e_o     = e_q;

endmodule
